// File: rtl/fifo_scd_thr.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a choice of first-word-fall-through or registered read.
module fifo_scd_thr #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1,
  parameter int FWFT      = 1
) (
  input  logic                         clk_i,
  input  logic                         arst_ni,
  input  logic                         flush_i,
  input  logic                         wen_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         ren_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         rvalid_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C   = CW'(AE_THRESH);
  localparam logic [PW-1:0] LAST_C = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             wr_acc;
  logic             rd_acc;

  // Flags decode straight from the registered count so they carry no extra latency.
  assign full_o         = (count == FULL_C);
  assign empty_o        = (count == '0);
  assign almost_full_o  = (count >= AF_C);
  assign almost_empty_o = (count <= AE_C);
  assign count_o        = count;

  assign wr_acc = wen_i && !full_o && !flush_i;
  assign rd_acc = ren_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      // Explicit wrap compare keeps non-power-of-two depths correct.
      if (wr_acc) wptr <= (wptr == LAST_C) ? '0 : wptr + 1'b1;
      if (rd_acc) rptr <= (rptr == LAST_C) ? '0 : rptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wen_i && full_o)  overflow_o  <= 1'b1;
      if (ren_i && empty_o) underflow_o <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wptr] <= data_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_o   = mem[rptr];
      assign rvalid_o = !empty_o;
    end else begin : g_reg
      logic [WIDTH-1:0] rdata;
      logic             rvalid;

      always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else if (flush_i) begin
          rvalid <= 1'b0;
        end else begin
          rvalid <= rd_acc;
          if (rd_acc) rdata <= mem[rptr];
        end
      end

      assign data_o   = rdata;
      assign rvalid_o = rvalid;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_scd_thr.sv
// Drives an FWFT and a registered-read FIFO with the same stimulus and checks
// both against a queue-based reference model plus directed literal expectations.
module tb_fifo_scd_thr;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int AF = 4;
  localparam int AE = 1;
  localparam int CW = $clog2(D + 1);

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic         flush = 1'b0;
  logic         wen = 1'b0;
  logic         ren = 1'b0;
  logic [W-1:0] din = '0;

  logic [W-1:0]  data_f, data_r;
  logic          rvalid_f, rvalid_r, full_f, full_r, empty_f, empty_r;
  logic          af_f, af_r, ae_f, ae_r, ovf_f, ovf_r, unf_f, unf_r;
  logic [CW-1:0] count_f, count_r;

  fifo_scd_thr #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(1)) u_fwft (
    .clk_i(clk), .arst_ni(arst_n), .flush_i(flush), .wen_i(wen), .data_i(din), .ren_i(ren),
    .data_o(data_f), .rvalid_o(rvalid_f), .full_o(full_f), .empty_o(empty_f),
    .almost_full_o(af_f), .almost_empty_o(ae_f), .count_o(count_f),
    .overflow_o(ovf_f), .underflow_o(unf_f));

  fifo_scd_thr #(.WIDTH(W), .DEPTH(D), .AF_THRESH(AF), .AE_THRESH(AE), .FWFT(0)) u_reg (
    .clk_i(clk), .arst_ni(arst_n), .flush_i(flush), .wen_i(wen), .data_i(din), .ren_i(ren),
    .data_o(data_r), .rvalid_o(rvalid_r), .full_o(full_r), .empty_o(empty_r),
    .almost_full_o(af_r), .almost_empty_o(ae_r), .count_o(count_r),
    .overflow_o(ovf_r), .underflow_o(unf_r));

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, flags and the registered read port as plain bits.
  logic [W-1:0] q[$];
  bit           m_ovf, m_unf, m_rv, m_full, m_empty, m_wa, m_ra;
  logic [W-1:0] m_rd;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
    end else begin
      m_full  = (q.size() == D);
      m_empty = (q.size() == 0);
      if (flush) begin
        q.delete();
        m_ovf = 0; m_unf = 0; m_rv = 0;
      end else begin
        m_wa = wen && !m_full;
        m_ra = ren && !m_empty;
        if (wen && m_full)  m_ovf = 1;
        if (ren && m_empty) m_unf = 1;
        m_rv = m_ra;
        if (m_ra) m_rd = q.pop_front();
        if (m_wa) q.push_back(din);
      end
    end
  end

  // Every falling edge, both DUTs are compared against the model.
  always @(negedge clk) begin
    int n;
    n = q.size();
    checkOutput("count_f", 32'(count_f), 32'(n));
    checkOutput("count_r", 32'(count_r), 32'(n));
    checkOutput("empty_f", 32'(empty_f), 32'(n == 0));
    checkOutput("empty_r", 32'(empty_r), 32'(n == 0));
    checkOutput("full_f", 32'(full_f), 32'(n == D));
    checkOutput("full_r", 32'(full_r), 32'(n == D));
    checkOutput("af_f", 32'(af_f), 32'(n >= AF));
    checkOutput("af_r", 32'(af_r), 32'(n >= AF));
    checkOutput("ae_f", 32'(ae_f), 32'(n <= AE));
    checkOutput("ae_r", 32'(ae_r), 32'(n <= AE));
    checkOutput("ovf_f", 32'(ovf_f), 32'(m_ovf));
    checkOutput("ovf_r", 32'(ovf_r), 32'(m_ovf));
    checkOutput("unf_f", 32'(unf_f), 32'(m_unf));
    checkOutput("unf_r", 32'(unf_r), 32'(m_unf));
    checkOutput("rvalid_f", 32'(rvalid_f), 32'(n != 0));
    if (n != 0) checkOutput("data_f", 32'(data_f), 32'(q[0]));
    checkOutput("rvalid_r", 32'(rvalid_r), 32'(m_rv));
    checkOutput("data_r", 32'(data_r), 32'(m_rd));
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic applyStimulus(input bit w, input logic [W-1:0] d, input bit r, input bit f);
    wen = w; din = d; ren = r; flush = f;
    @(posedge clk);
    #1;
    wen = 0; ren = 0; flush = 0;
  endtask

  task automatic doFlush();
    applyStimulus(0, '0, 0, 1);
  endtask

  initial begin
    // Reset state
    arst_n = 0;
    @(posedge clk); #1;
    checkOutput("rst_count", 32'(count_f), 0);
    checkOutput("rst_empty", 32'(empty_r), 1);
    checkOutput("rst_ae", 32'(ae_f), 1);
    checkOutput("rst_af", 32'(af_r), 0);
    checkOutput("rst_data_r", 32'(data_r), 0);
    checkOutput("rst_rvalid_r", 32'(rvalid_r), 0);
    arst_n = 1;
    @(posedge clk); #1;

    // Single word latency in both read modes
    applyStimulus(1, 8'hA5, 0, 0);
    checkOutput("fwft_data_a5", 32'(data_f), 32'hA5);
    checkOutput("fwft_rvalid_a5", 32'(rvalid_f), 1);
    checkOutput("empty_after_wr", 32'(empty_r), 0);
    checkOutput("reg_rvalid_pre", 32'(rvalid_r), 0);
    applyStimulus(0, '0, 1, 0);
    checkOutput("reg_rvalid_a5", 32'(rvalid_r), 1);
    checkOutput("reg_data_a5", 32'(data_r), 32'hA5);
    applyStimulus(0, '0, 0, 0);
    checkOutput("reg_rvalid_drop", 32'(rvalid_r), 0);
    checkOutput("reg_data_hold", 32'(data_r), 32'hA5);

    // Read on empty
    applyStimulus(0, '0, 1, 0);
    checkOutput("unf_set", 32'(unf_f), 1);
    checkOutput("unf_count", 32'(count_r), 0);
    checkOutput("unf_rvalid_r", 32'(rvalid_r), 0);
    doFlush();
    checkOutput("unf_flushed", 32'(unf_r), 0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'(8'h11 + i), 0, 0);
      checkOutput("fill_count", 32'(count_f), 32'(i + 1));
      checkOutput("fill_af", 32'(af_r), 32'(i >= 3));
      checkOutput("fill_full", 32'(full_f), 32'(i == 4));
    end
    applyStimulus(1, 8'h16, 0, 0);
    checkOutput("ovf_set", 32'(ovf_r), 1);
    checkOutput("ovf_count", 32'(count_r), 5);
    for (int i = 0; i < 5; i++) begin
      checkOutput("drain_fwft", 32'(data_f), 32'(8'h11 + i));
      applyStimulus(0, '0, 1, 0);
      checkOutput("drain_reg", 32'(data_r), 32'(8'h11 + i));
    end
    checkOutput("drain_empty", 32'(empty_f), 1);
    doFlush();

    // Pointer wrap with bursts of three
    for (int rep = 0; rep < 4; rep++) begin
      for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h40 + rep * 3 + i), 0, 0);
      for (int i = 0; i < 3; i++) begin
        applyStimulus(0, '0, 1, 0);
        checkOutput("wrap_data", 32'(data_r), 32'(8'h40 + rep * 3 + i));
      end
    end

    // Simultaneous read/write at steady occupancy, then at full
    applyStimulus(1, 8'h30, 0, 0);
    applyStimulus(1, 8'h31, 0, 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 8'(8'h32 + i), 1, 0);
      checkOutput("rw_count", 32'(count_f), 2);
      checkOutput("rw_data", 32'(data_r), 32'(8'h30 + i));
    end
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h50 + i), 0, 0);
    applyStimulus(1, 8'h60, 1, 0);
    checkOutput("full_rw_count", 32'(count_r), 4);
    checkOutput("full_rw_ovf", 32'(ovf_f), 1);

    // Flush with write while overflow is set
    applyStimulus(1, 8'h61, 0, 0);
    applyStimulus(0, '0, 1, 0);
    applyStimulus(0, '0, 1, 0);
    checkOutput("pre_flush_count", 32'(count_f), 3);
    applyStimulus(1, 8'h62, 0, 1);
    checkOutput("flush_count", 32'(count_f), 0);
    checkOutput("flush_ovf", 32'(ovf_r), 0);
    checkOutput("flush_empty", 32'(empty_r), 1);

    // Asynchronous reset mid-operation discards contents
    for (int i = 0; i < 3; i++) applyStimulus(1, 8'(8'h70 + i), 0, 0);
    #2 arst_n = 0;
    #1;
    checkOutput("arst_count", 32'(count_r), 0);
    checkOutput("arst_empty", 32'(empty_f), 1);
    @(posedge clk); #1;
    arst_n = 1;
    applyStimulus(1, 8'h77, 0, 0);
    checkOutput("post_rst_fwft", 32'(data_f), 32'h77);
    applyStimulus(0, '0, 1, 0);
    checkOutput("post_rst_reg", 32'(data_r), 32'h77);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 55), 8'($urandom),
                    1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 63) == 0));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
